// File: rtl/regincr_pkg.sv
// regincr_pkg: shared datapath width and data type for the registered incrementer chain.
package regincr_pkg;
    localparam int REGINCR_NBITS = 8;
    typedef logic [REGINCR_NBITS-1:0] regincr_data_t;
endpackage

// File: rtl/regincr_out_fifo_if.sv
// regincr_out_fifo_if: producer, consumer and status signals of the output FIFO.
interface regincr_out_fifo_if
    import regincr_pkg::*;
#(
    parameter int p_nbits = REGINCR_NBITS,
    parameter int p_depth = 4
);
    logic                       in_val;
    logic [p_nbits-1:0]         in_msg;
    logic                       out_val;
    logic                       out_rdy;
    logic [p_nbits-1:0]         out_msg;
    logic [$clog2(p_depth):0]   count;
    logic                       overflow;
    logic                       clear_ovf;

    modport master (
        output in_val, in_msg, out_rdy, clear_ovf,
        input  out_val, out_msg, count, overflow
    );

    modport slave (
        input  in_val, in_msg, out_rdy, clear_ovf,
        output out_val, out_msg, count, overflow
    );
endinterface

// File: rtl/regincr_fifo_rf.sv
// regincr_fifo_rf: p_depth x p_nbits storage, one synchronous write port and
// one combinational read port; contents are intentionally not reset.
module regincr_fifo_rf
    import regincr_pkg::*;
#(
    parameter int p_nbits = REGINCR_NBITS,
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       wen,
    input  logic [$clog2(p_depth)-1:0] waddr,
    input  logic [p_nbits-1:0]         wdata,
    input  logic [$clog2(p_depth)-1:0] raddr,
    output logic [p_nbits-1:0]         rdata
);
    logic [p_nbits-1:0] mem_q [p_depth];

    always_ff @(posedge clk) begin
        if (wen) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/regincr_out_fifo.sv
// regincr_out_fifo: circular FIFO decoupling the free-running incrementer from a
// val/rdy consumer; inputs arriving while full are dropped and flagged in a sticky overflow.
module regincr_out_fifo
    import regincr_pkg::*;
#(
    parameter int p_nbits = REGINCR_NBITS,
    parameter int p_depth = 4
) (
    input logic                clk,
    input logic                reset_n,
    regincr_out_fifo_if.slave  io
);
    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, enq, deq, drop;

    always_comb begin
        full       = count_q == CW'(p_depth);
        deq        = (count_q != '0) & io.out_rdy;
        // a dequeue on the same edge frees a slot, so a full FIFO can still accept
        enq        = io.in_val & (!full | deq);
        drop       = io.in_val & full & !deq;
        wr_ptr_d   = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(enq) - CW'(deq);
        overflow_d = drop ? 1'b1 : io.clear_ovf ? 1'b0 : overflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    regincr_fifo_rf #(
        .p_nbits (p_nbits),
        .p_depth (p_depth)
    ) u_rf (
        .clk   (clk),
        .wen   (enq),
        .waddr (wr_ptr_q),
        .wdata (io.in_msg),
        .raddr (rd_ptr_q),
        .rdata (io.out_msg)
    );

    assign io.out_val  = count_q != '0;
    assign io.count    = count_q;
    assign io.overflow = overflow_q;
endmodule

// File: tb/tb_regincr_out_fifo.sv
// tb_regincr_out_fifo: directed scenario tasks for regincr_out_fifo with hand-computed expectations.
module tb_regincr_out_fifo;
    import regincr_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    regincr_out_fifo_if #(.p_nbits(8), .p_depth(4)) io ();

    regincr_out_fifo #(.p_nbits(8), .p_depth(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input regincr_data_t base);
        io.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io.in_val = 1'b1;
            io.in_msg = regincr_data_t'(base + i);
            tick();
        end
        io.in_val = 1'b0;
    endtask

    task automatic drain(input regincr_data_t base, input string tag);
        io.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (io.out_val !== 1'b1 || io.out_msg !== regincr_data_t'(base + i)) begin
                errors++;
                $display("FAIL %s drain[%0d] val=%b msg=%h want val=1 msg=%h", tag, i, io.out_val, io.out_msg, regincr_data_t'(base + i));
            end
            tick();
        end
        io.out_rdy = 1'b0;
        checks++;
        if (io.count !== 3'd0 || io.out_val !== 1'b0) begin
            errors++;
            $display("FAIL %s drained count=%0d val=%b want count=0 val=0", tag, io.count, io.out_val);
        end
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 5; i++) begin
            io.in_val = 1'b1;
            io.in_msg = regincr_data_t'(i);
            tick();
        end
        io.in_val = 1'b0;
        checks++;
        if (io.count !== 3'd4 || io.overflow !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill count=%0d ovf=%b want count=4 ovf=1", io.count, io.overflow);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (io.out_val !== 1'b0 || io.count !== 3'd0 || io.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset val=%b count=%0d ovf=%b want 0 0 0", io.out_val, io.count, io.overflow);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (io.out_val !== 1'b0 || io.count !== 3'd0) begin
                errors++;
                $display("FAIL idle[%0d] val=%b count=%0d want val=0 count=0", i, io.out_val, io.count);
            end
        end
    endtask

    task automatic test_single();
        io.in_val = 1'b1;
        io.in_msg = 8'h2A;
        tick();
        io.in_val = 1'b0;
        checks++;
        if (io.out_val !== 1'b1 || io.out_msg !== 8'h2A || io.count !== 3'd1) begin
            errors++;
            $display("FAIL single val=%b msg=%h count=%0d want 1 2a 1", io.out_val, io.out_msg, io.count);
        end
        io.out_rdy = 1'b1;
        tick();
        io.out_rdy = 1'b0;
        checks++;
        if (io.count !== 3'd0 || io.out_val !== 1'b0) begin
            errors++;
            $display("FAIL single_deq count=%0d val=%b want count=0 val=0", io.count, io.out_val);
        end
    endtask

    task automatic test_fill_overflow();
        io.out_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            io.in_val = 1'b1;
            io.in_msg = regincr_data_t'(i);
            tick();
        end
        io.in_val = 1'b0;
        checks++;
        if (io.count !== 3'd4 || io.overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_ovf count=%0d ovf=%b want count=4 ovf=1", io.count, io.overflow);
        end
        drain(8'h01, "fill_ovf");
        io.clear_ovf = 1'b1;
        tick();
        io.clear_ovf = 1'b0;
        checks++;
        if (io.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_ovf ovf=%b want 0", io.overflow);
        end
    endtask

    task automatic test_full_deq();
        fill(8'h10);
        io.in_val = 1'b1;
        io.in_msg = 8'h14;
        io.out_rdy = 1'b1;
        tick();
        io.in_val = 1'b0;
        io.out_rdy = 1'b0;
        checks++;
        if (io.overflow !== 1'b0 || io.count !== 3'd4) begin
            errors++;
            $display("FAIL full_deq ovf=%b count=%0d want ovf=0 count=4", io.overflow, io.count);
        end
        drain(8'h11, "full_deq");
    endtask

    task automatic test_stream(input regincr_data_t base);
        io.in_val = 1'b1;
        io.out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            io.in_msg = regincr_data_t'(base + i);
            tick();
            checks++;
            if (io.out_val !== 1'b1 || io.out_msg !== regincr_data_t'(base + i) || io.count !== 3'd1) begin
                errors++;
                $display("FAIL stream[%h+%0d] val=%b msg=%h count=%0d want 1 %h 1", base, i, io.out_val, io.out_msg, io.count, regincr_data_t'(base + i));
            end
        end
        io.in_val = 1'b0;
        tick();
        io.out_rdy = 1'b0;
        checks++;
        if (io.count !== 3'd0) begin
            errors++;
            $display("FAIL stream_end count=%0d want 0", io.count);
        end
    endtask

    task automatic test_ovf_priority();
        fill(8'hA0);
        io.in_val = 1'b1;
        io.in_msg = 8'h55;
        io.clear_ovf = 1'b1;
        tick();
        io.in_val = 1'b0;
        checks++;
        if (io.overflow !== 1'b1 || io.count !== 3'd4 || io.out_msg !== 8'hA0) begin
            errors++;
            $display("FAIL drop_beats_clear ovf=%b count=%0d msg=%h want 1 4 a0", io.overflow, io.count, io.out_msg);
        end
        tick();
        io.clear_ovf = 1'b0;
        checks++;
        if (io.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_after ovf=%b want 0", io.overflow);
        end
        drain(8'hA0, "ovf_prio");
    endtask

    task automatic test_idle_noise();
        io.in_val = 1'b0;
        io.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io.in_msg = regincr_data_t'(8'h5A ^ (i * 8'h33));
            tick();
        end
        io.out_rdy = 1'b0;
        checks++;
        if (io.count !== 3'd0 || io.out_val !== 1'b0 || io.overflow !== 1'b0) begin
            errors++;
            $display("FAIL idle_noise count=%0d val=%b ovf=%b want 0 0 0", io.count, io.out_val, io.overflow);
        end
    endtask

    initial begin
        io.in_val = 1'b0;
        io.in_msg = '0;
        io.out_rdy = 1'b0;
        io.clear_ovf = 1'b0;
        #1;
        checks++;
        if (io.out_val !== 1'b0 || io.count !== 3'd0 || io.overflow !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset val=%b count=%0d ovf=%b want 0 0 0", io.out_val, io.count, io.overflow);
        end
        tick();
        tick();
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_deq();
        test_stream(8'h00);
        test_stream(8'hF6);
        test_ovf_priority();
        test_idle_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
